hand_frame_streamer: RTL and testbench
======================================

Name: hand_frame_streamer

Overview:
- Downstream stage of the sorter and upstream of uart_tx.
- Latches one sorted 17-card hand (136 bits, one byte per card) and serialises it into a framed byte stream: header, card count, each non-empty card, XOR checksum.
- Drives uart_tx one byte at a time using the pi_flag/tx_done handshake.
- Replaces ad-hoc hand dumps, so the host can validate hands.

Parameters:
- NUM_CARDS, 17: card slots in hand_data.
- HEADER, 8'hAA: first byte of every frame.
- EMPTY_CODE, 8'h00: slot value meaning "no card"; such slots are skipped.
- TX_TIMEOUT, 24'd2_000_000: maximum WAIT cycles for tx_done before the frame is aborted.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- hand_valid  in  1  single-cycle pulse; hand_data is valid this cycle.
- hand_data  in  136  card i = bits [135-8i -: 8]; card 0 (MSB byte) is sent first.
- tx_done  in  1  one-cycle pulse from uart_tx when a byte's stop bit completes.
- tx_flag  out  1  one-cycle send request to uart_tx pi_flag.
- tx_byte  out  8  byte for uart_tx pi_data; stable from tx_flag until tx_done.
- busy  out  1  high from the cycle after hand_valid is accepted until return to IDLE.
- frame_done  out  1  one-cycle pulse after the checksum byte's tx_done.
- err_timeout  out  1  one-cycle pulse when a frame is aborted.
- overrun  out  1  one-cycle pulse when hand_valid arrives while busy.

Behaviour:
- Reset values:
  - All outputs 0; tx_byte 8'h00.
  - State IDLE; shadow hand, index, count, checksum and timeout counter all 0.
  - Reset is effective mid-frame: no further tx_flag is issued.
- States: IDLE, COUNT, ISSUE, WAIT, SKIP, DONE, ABORT.
- IDLE:
  - On hand_valid, copy hand_data to the shadow register, set idx=0, cnt=0, go to COUNT.
  - tx_done is ignored in IDLE.
- COUNT:
  - One slot per cycle, idx 0..NUM_CARDS-1; cnt increments when slot != EMPTY_CODE.
  - Takes exactly NUM_CARDS cycles, then sets phase=HDR, chk=cnt, and goes to ISSUE.
  - cnt is 8 bits wide; its maximum is NUM_CARDS.
- ISSUE:
  - Registered Moore output: tx_flag=1 for exactly this cycle.
  - tx_byte by phase: HDR→HEADER, CNT→cnt, CARD→slot[idx], CHK→chk.
  - Always goes to WAIT next; the timeout counter clears.
- WAIT:
  - On tx_done, advance the phase:
    - HDR→CNT, then ISSUE.
    - CNT→CARD with idx=0, then SKIP.
    - CARD→chk^=slot[idx], idx++, then SKIP.
    - CHK→DONE.
  - Otherwise the counter increments.
  - If TX_TIMEOUT WAIT cycles elapse with no tx_done, go to ABORT.
  - If tx_done coincides with the final counted cycle, tx_done wins.
- SKIP:
  - If idx==NUM_CARDS: phase=CHK, go to ISSUE.
  - Else if slot[idx]==EMPTY_CODE: idx++ and stay in SKIP (one slot per cycle).
  - Else go to ISSUE.
- DONE: frame_done=1 for one cycle, then IDLE.
- ABORT: err_timeout=1 for one cycle, then IDLE; the partial frame is not resumed.
- Latency:
  - hand_valid sampled at cycle t gives the header tx_flag at t+NUM_CARDS+1.
  - Consecutive tx_flags: tx_done cycle +1 when no empties are skipped, plus one cycle per skipped slot.
- Framing and checksum:
  - Frame length = cnt+3 bytes.
  - An empty hand sends HEADER, 00, 00.
  - Checksum = cnt XOR all sent card bytes.
- Busy handling:
  - hand_valid while busy (any state other than IDLE) is ignored: shadow is unchanged, overrun=1 next cycle.
  - busy=1 in every non-IDLE state.
- tx_byte holds its value after tx_flag until the next ISSUE.

Test Plan:
- Partial hand: slots 0..2 = 3E,3D,2C, rest 00 → bytes AA,03,3E,3D,2C,2C; frame_done once; first tx_flag exactly 18 cycles after hand_valid.
- Full hand: all 17 slots = 11 → 20 bytes: AA,11, then seventeen 11, then checksum 00.
- Empty hand: all 00 → AA,00,00; no card bytes issued.
- Holes: slots 0=44, 5=21, 16=05, rest 00 → AA,03,44,21,05,63.
  - Gap between tx_done(44) and tx_flag(21) is 5 cycles.
  - Gap after 05 before the checksum tx_flag is 1 cycle.
- Timeout (TX_TIMEOUT=100):
  - Withhold tx_done after the header tx_flag at cycle T → err_timeout at T+102, busy low at T+102, no further tx_flag.
  - A later valid hand streams normally.
- Overrun/reset:
  - hand_valid during COUNT → overrun pulse; the original frame is sent unchanged.
  - sys_rst_n low during WAIT → all outputs 0 immediately; no tx_flag after release until a new hand_valid.

Source files
------------

// File: rtl/hand_frame_streamer.sv
// hand_frame_streamer
// Latches one sorted hand and sends it to uart_tx as a framed byte stream:
//   HEADER, card count, each non-empty card (slot 0 first), XOR checksum.
// The checksum is the count XORed with every card byte that was sent.
//
// Ports
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   hand_valid   single-cycle pulse, hand_data valid this cycle
//   hand_data    card i = bits [8*NUM_CARDS-1-8i -: 8]
//   tx_done      one-cycle pulse from uart_tx when a byte's stop bit ends
//   tx_flag      one-cycle send request to uart_tx
//   tx_byte      byte to send, held from tx_flag until the next request
//   busy         high while a frame is in progress
//   frame_done   one-cycle pulse after the checksum byte completes
//   err_timeout  one-cycle pulse when a frame is aborted on a missing tx_done
//   overrun      one-cycle pulse when hand_valid arrives while busy
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for hand_valid
// COUNT  | walking the shadow hand once, counting non-empty slots
// ISSUE  | tx_flag high for this cycle, tx_byte holds the byte
// WAIT   | waiting for tx_done, timeout counter running
// SKIP   | stepping over empty slots, one per cycle
// DONE   | frame complete, frame_done pulses next cycle
// ABORT  | tx_done never came, err_timeout pulses next cycle
module hand_frame_streamer #(
  parameter int          NUM_CARDS  = 17,
  parameter logic [7:0]  HEADER     = 8'hAA,
  parameter logic [7:0]  EMPTY_CODE = 8'h00,
  parameter logic [23:0] TX_TIMEOUT = 24'd2_000_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   hand_valid,
  input  logic [8*NUM_CARDS-1:0] hand_data,
  input  logic                   tx_done,
  output logic                   tx_flag,
  output logic [7:0]             tx_byte,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_timeout,
  output logic                   overrun
);

  localparam int             HW       = 8 * NUM_CARDS;
  localparam int             IW       = $clog2(NUM_CARDS + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_CARDS - 1);
  localparam logic [IW-1:0]  END_IDX  = IW'(NUM_CARDS);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_ISSUE, S_WAIT, S_SKIP, S_DONE, S_ABORT
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR, PH_CNT, PH_CARD, PH_CHK
  } phase_t;

  state_t         state;
  phase_t         phase;
  logic [HW-1:0]  shadow;
  logic [IW-1:0]  idx;
  logic [7:0]     cnt;
  logic [7:0]     chk;
  logic [23:0]    timer;

  logic [7:0]     cur_slot;
  logic [7:0]     cnt_inc;
  logic [IW-1:0]  cand_idx;
  logic [7:0]     cand_slot;
  logic           cand_end;
  logic           cand_empty;
  logic [7:0]     chk_adv;

  // Out-of-range indices read as empty so the lookahead past the last slot
  // is harmless.
  function automatic logic [7:0] slot_of(input logic [HW-1:0] h,
                                         input logic [IW-1:0] i);
    logic [7:0] s;
    s = EMPTY_CODE;
    for (int k = 0; k < NUM_CARDS; k++) begin
      if (i == IW'(k)) s = h[HW-1-8*k -: 8];
    end
    return s;
  endfunction

  // Candidate slot for the next card byte. Looking one slot ahead lets the
  // byte after tx_done be issued on the next cycle when no empties sit in
  // between; each empty slot then costs exactly one SKIP cycle.
  always_comb begin
    cur_slot   = slot_of(shadow, idx);
    cnt_inc    = cnt + {7'd0, (cur_slot != EMPTY_CODE)};
    cand_idx   = (phase == PH_CNT) ? '0 : idx + IW'(1);
    cand_slot  = slot_of(shadow, cand_idx);
    cand_end   = (cand_idx == END_IDX);
    cand_empty = (cand_slot == EMPTY_CODE);
    chk_adv    = ((state == S_WAIT) && (phase == PH_CARD)) ? (chk ^ cur_slot) : chk;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      phase       <= PH_HDR;
      shadow      <= '0;
      idx         <= '0;
      cnt         <= 8'h00;
      chk         <= 8'h00;
      timer       <= 24'd0;
      tx_flag     <= 1'b0;
      tx_byte     <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      tx_flag     <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= hand_valid && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (hand_valid) begin
            shadow <= hand_data;
            idx    <= '0;
            cnt    <= 8'h00;
            busy   <= 1'b1;
            state  <= S_COUNT;
          end
        end

        S_COUNT: begin
          cnt <= cnt_inc;
          if (idx == LAST_IDX) begin
            phase   <= PH_HDR;
            chk     <= cnt_inc;
            tx_flag <= 1'b1;
            tx_byte <= HEADER;
            state   <= S_ISSUE;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        S_ISSUE: begin
          timer <= 24'd0;
          state <= S_WAIT;
        end

        S_WAIT, S_SKIP: begin
          if ((state == S_WAIT) && !tx_done) begin
            if (timer == TX_TIMEOUT - 24'd1) state <= S_ABORT;
            else                             timer <= timer + 24'd1;
          end else if ((state == S_WAIT) && (phase == PH_HDR)) begin
            phase   <= PH_CNT;
            tx_flag <= 1'b1;
            tx_byte <= cnt;
            state   <= S_ISSUE;
          end else if ((state == S_WAIT) && (phase == PH_CHK)) begin
            state <= S_DONE;
          end else begin
            // card advance: after the count byte, after a card byte, or a skip
            chk <= chk_adv;
            if (cand_end) begin
              phase   <= PH_CHK;
              tx_flag <= 1'b1;
              tx_byte <= chk_adv;
              state   <= S_ISSUE;
            end else if (cand_empty) begin
              phase <= PH_CARD;
              idx   <= cand_idx;
              state <= S_SKIP;
            end else begin
              phase   <= PH_CARD;
              idx     <= cand_idx;
              tx_flag <= 1'b1;
              tx_byte <= cand_slot;
              state   <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        S_ABORT: begin
          err_timeout <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hand_frame_streamer.sv
// Directed bench for hand_frame_streamer with a small uart_tx responder that
// answers each tx_flag with tx_done three cycles later.
// Time stamps: inputs are stamped at the cycle they are driven, outputs at the
// cycle they are observed, so a stamp difference equals the edge latency.
module tb_hand_frame_streamer;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         hand_valid = 1'b0;
  logic [135:0] hand_data = '0;
  logic         tx_done = 1'b0;
  logic         tx_flag;
  logic [7:0]   tx_byte;
  logic         busy;
  logic         frame_done;
  logic         err_timeout;
  logic         overrun;

  hand_frame_streamer #(
    .NUM_CARDS  (17),
    .HEADER     (8'hAA),
    .EMPTY_CODE (8'h00),
    .TX_TIMEOUT (24'd100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .hand_valid  (hand_valid),
    .hand_data   (hand_data),
    .tx_done     (tx_done),
    .tx_flag     (tx_flag),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [135:0] H_PARTIAL = {8'h3E, 8'h3D, 8'h2C, {14{8'h00}}};
  localparam logic [135:0] H_FULL    = {17{8'h11}};
  localparam logic [135:0] H_EMPTY   = '0;
  localparam logic [135:0] H_HOLES   = {8'h44, {4{8'h00}}, 8'h21, {10{8'h00}}, 8'h05};
  localparam logic [135:0] H_ALT     = {17{8'h77}};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] got [0:31];
  int         flag_cyc [0:31];
  int         done_cyc [0:31];
  int         n_got, n_done, n_err, n_ovr, n_flags;
  int         t0, err_cyc, ovr_cyc, ovr_drv;
  logic       hold_bad, busy_at_err, busy_first;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input logic [135:0] hand, input int resp_lim,
                           input int ovr_at, input int cycles);
    int cd;
    cd = 0;
    n_got = 0; n_done = 0; n_err = 0; n_ovr = 0;
    err_cyc = -1; ovr_cyc = -1; ovr_drv = -1;
    hold_bad = 1'b0; busy_at_err = 1'b1;
    hand_data = hand;
    hand_valid = 1'b1;
    t0 = cyc;
    tick();
    hand_valid = 1'b0;
    busy_first = busy;
    for (int k = 0; k < cycles; k++) begin
      tx_done = 1'b0;
      if (tx_flag && n_got < 32) begin
        got[n_got] = tx_byte;
        flag_cyc[n_got] = cyc;
        n_got++;
        if (n_got <= resp_lim) cd = 3;
      end else if (cd > 0) begin
        if (tx_byte !== got[n_got-1]) hold_bad = 1'b1;
        cd--;
        if (cd == 0) begin
          tx_done = 1'b1;
          done_cyc[n_got-1] = cyc;
        end
      end
      if (frame_done) n_done++;
      if (err_timeout) begin
        n_err++;
        err_cyc = cyc;
        busy_at_err = busy;
      end
      if (overrun) begin
        n_ovr++;
        ovr_cyc = cyc;
      end
      hand_valid = (k == ovr_at);
      if (k == ovr_at) begin
        hand_data = H_ALT;
        ovr_drv = cyc;
      end
      tick();
    end
    tx_done = 1'b0;
    hand_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 32'(n_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    check({tag, "_done"}, 32'(n_done), 32'd1);
    check({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
  endtask

  initial begin
    // reset state
    #1;
    check("rst_outs", {18'd0, tx_flag, tx_byte, busy, frame_done, err_timeout, overrun}, 32'd0);
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // partial hand
    exp_q = '{8'hAA, 8'h03, 8'h3E, 8'h3D, 8'h2C, 8'h2C};
    run_frame(H_PARTIAL, 99, -1, 250);
    check_frame("partial");
    check("partial_latency", 32'(flag_cyc[0] - t0), 32'd18);
    check("partial_busy_first", {31'd0, busy_first}, 32'd1);
    check("partial_hdr_gap", 32'(flag_cyc[1] - done_cyc[0]), 32'd1);
    check("partial_idle", {31'd0, busy}, 32'd0);

    // full hand
    exp_q = '{8'hAA, 8'h11};
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h11);
    exp_q.push_back(8'h00);
    run_frame(H_FULL, 99, -1, 250);
    check_frame("full");

    // empty hand
    exp_q = '{8'hAA, 8'h00, 8'h00};
    run_frame(H_EMPTY, 99, -1, 250);
    check_frame("empty");

    // holes
    exp_q = '{8'hAA, 8'h03, 8'h44, 8'h21, 8'h05, 8'h63};
    run_frame(H_HOLES, 99, -1, 250);
    check_frame("holes");
    check("holes_gap_skip4", 32'(flag_cyc[3] - done_cyc[2]), 32'd5);
    check("holes_gap_chk", 32'(flag_cyc[5] - done_cyc[4]), 32'd1);

    // timeout: header never acknowledged
    run_frame(H_PARTIAL, 0, -1, 200);
    check("to_flags", 32'(n_got), 32'd1);
    check("to_err_count", 32'(n_err), 32'd1);
    check("to_err_time", 32'(err_cyc - flag_cyc[0]), 32'd102);
    check("to_busy_at_err", {31'd0, busy_at_err}, 32'd0);
    check("to_no_done", 32'(n_done), 32'd0);

    // next hand after abort streams normally
    exp_q = '{8'hAA, 8'h03, 8'h3E, 8'h3D, 8'h2C, 8'h2C};
    run_frame(H_PARTIAL, 99, -1, 250);
    check_frame("after_to");
    check("after_to_err", 32'(n_err), 32'd0);

    // overrun during COUNT
    run_frame(H_PARTIAL, 99, 5, 250);
    check_frame("ovr");
    check("ovr_count", 32'(n_ovr), 32'd1);
    check("ovr_time", 32'(ovr_cyc - ovr_drv), 32'd1);

    // reset during WAIT
    hand_data = H_PARTIAL;
    hand_valid = 1'b1;
    tick();
    hand_valid = 1'b0;
    for (int k = 0; k < 40 && !tx_flag; k++) tick();
    check("rstw_flag", {31'd0, tx_flag}, 32'd1);
    tick(); tick();
    check("rstw_pre", {23'd0, busy, tx_byte}, {23'd0, 1'b1, 8'hAA});
    sys_rst_n = 1'b0;
    #1;
    check("rstw_outs", {18'd0, tx_flag, tx_byte, busy, frame_done, err_timeout, overrun}, 32'd0);
    tick(); tick();
    sys_rst_n = 1'b1;
    n_flags = 0;
    for (int k = 0; k < 60; k++) begin
      tx_done = (k == 3) || (k == 20);
      if (tx_flag) n_flags++;
      tick();
    end
    tx_done = 1'b0;
    check("rstw_no_flag", 32'(n_flags), 32'd0);
    check("rstw_idle", {31'd0, busy}, 32'd0);

    exp_q = '{8'hAA, 8'h03, 8'h44, 8'h21, 8'h05, 8'h63};
    run_frame(H_HOLES, 99, -1, 250);
    check_frame("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
